// File: rtl/fifo_wr_cntrl.sv
// fifo_wr_cntrl: write-side steering controller for the per-switch FIFO bank.
// Takes a framed byte stream and decodes the destination from the header beat.
// The whole packet is then written into one switch FIFO. Packets whose header
// maps to no FIFO are swallowed and counted in a saturating drop counter.
module fifo_wr_cntrl #(
   parameter int unsigned         NUM_SW_INST = 5,
   parameter int unsigned         W_WIDTH     = 8,
   parameter logic [W_WIDTH-1:0]  ADDR_BASE   = 8'h10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [W_WIDTH-1:0]     in_data,
   input  logic                   in_valid,
   input  logic                   in_sop,
   input  logic                   in_eop,
   output logic                   in_ready,
   input  logic [NUM_SW_INST-1:0] full,
   output logic [NUM_SW_INST-1:0] wr_en,
   output logic [W_WIDTH-1:0]     wr_data,
   output logic [15:0]            drop_cnt,
   output logic                   orphan
);

   localparam int unsigned DEST_W = $clog2(NUM_SW_INST);
   localparam logic [NUM_SW_INST-1:0] ONE_HOT_0 = NUM_SW_INST'(1);

   typedef enum logic [1:0] {
      IDLE,
      HDR_WAIT,
      FWD,
      DROP
   } state_t;

   state_t               state;
   logic [DEST_W-1:0]    dest;
   logic [W_WIDTH-1:0]   hdr;
   logic                 hdr_eop;

   // Header decode. Subtracting first means the upper bound never overflows
   // W_WIDTH, whatever ADDR_BASE is.
   logic [W_WIDTH-1:0]     offset;
   logic                   mapped;
   logic [DEST_W-1:0]      dec_idx;
   logic [NUM_SW_INST-1:0] full_sh_dec;
   logic [NUM_SW_INST-1:0] full_sh_dest;
   logic                   full_dec;
   logic                   full_dest;
   logic                   xfer;

   assign offset       = in_data - ADDR_BASE;
   assign mapped       = (in_data >= ADDR_BASE) && (offset < W_WIDTH'(NUM_SW_INST));
   assign dec_idx      = offset[DEST_W-1:0];
   // Shift-then-bit-0 keeps the per-FIFO lookup in range even when the index
   // is wider than the FIFO count.
   assign full_sh_dec  = full >> dec_idx;
   assign full_sh_dest = full >> dest;
   assign full_dec     = full_sh_dec[0];
   assign full_dest    = full_sh_dest[0];
   assign xfer         = in_valid && in_ready;

   // Ready is a function of state, latched destination and its full flag only.
   always_comb begin
      // NOTE: default first so every path assigns in_ready and no latch is inferred.
      in_ready = 1'b0;
      if (rst_n) begin
         unique case (state)
            IDLE:     in_ready = 1'b1;
            HDR_WAIT: in_ready = 1'b0;
            FWD:      in_ready = !full_dest;
            DROP:     in_ready = 1'b1;
            default:  in_ready = 1'b0;
         endcase
      end
   end

   // Packet FSM with registered write strobe, write data, orphan pulse and drop count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         dest     <= '0;
         hdr      <= '0;
         hdr_eop  <= 1'b0;
         wr_en    <= '0;
         wr_data  <= '0;
         drop_cnt <= '0;
         orphan   <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; the defaults below are overridden later
         // in the same block, which gives the single-cycle strobes.
         wr_en  <= '0;
         orphan <= 1'b0;
         unique case (state)
            IDLE: begin
               if (xfer) begin
                  if (!in_sop) begin
                     orphan <= 1'b1;
                  end else if (!mapped) begin
                     if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                     if (!in_eop) state <= DROP;
                  end else begin
                     dest <= dec_idx;
                     if (!full_dec) begin
                        wr_en   <= ONE_HOT_0 << dec_idx;
                        wr_data <= in_data;
                        if (!in_eop) state <= FWD;
                     end else begin
                        // Destination cannot take the header yet; park it.
                        hdr     <= in_data;
                        hdr_eop <= in_eop;
                        state   <= HDR_WAIT;
                     end
                  end
               end
            end
            HDR_WAIT: begin
               if (!full_dest) begin
                  wr_en   <= ONE_HOT_0 << dest;
                  wr_data <= hdr;
                  state   <= hdr_eop ? IDLE : FWD;
               end
            end
            FWD: begin
               // in_sop is deliberately ignored here; the beat is plain payload.
               if (xfer) begin
                  wr_en   <= ONE_HOT_0 << dest;
                  wr_data <= in_data;
                  if (in_eop) state <= IDLE;
               end
            end
            DROP: begin
               if (xfer && in_eop) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
